exe_muldiv_unit: RTL and testbench
==================================

// Module: exe_muldiv_unit
// PURPOSE
//  EXE-stage HI/LO multiply/divide unit, fed directly by the ID/EX pipeline register
//  (EXE_busA = rs, EXE_busB = rt, EXE_Funct). MULT/MULTU/MTHI/MTLO commit in one cycle.
//  DIV/DIVU run a 32-iteration radix-2 restoring divider and assert MdStall so that
//  PC, IF/ID and ID/EX are held. HI/LO are architectural registers read by MFHI/MFLO.
// PARAMETERS
//  WIDTH     32   operand width; HI/LO width; divider iteration count = WIDTH
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      synchronous reset, active-high
//  EXE_MdStart in   1      EXE instruction is valid and is a HI/LO-writing op
//  EXE_Funct   in   6      0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
//  EXE_busA    in   WIDTH  rs operand (already forwarded)
//  EXE_busB    in   WIDTH  rt operand (already forwarded)
//  Flush       in   1      exception/redirect: abort any op, no HI/LO write
//  MdStall     out  1      hold upstream pipeline (combinational)
//  MdDone      out  1      one-cycle pulse: divide result committed this edge
//  HI          out  WIDTH  HI register
//  LO          out  WIDTH  LO register
// BEHAVIOUR
//  Reset: HI=0, LO=0, state=IDLE, count=0, MdDone=0; MdStall=0 while rst high.
//  States: IDLE, DIV, DONE. rst > Flush > EXE_MdStart priority.
//  IDLE, start, MULT:  {HI,LO} <= signed(rs)*signed(rt) (2*WIDTH) at same edge; no stall.
//  IDLE, start, MULTU: {HI,LO} <= rs*rt unsigned; no stall.
//  IDLE, start, MTHI/MTLO: HI<=rs / LO<=rs at same edge; other reg unchanged.
//  IDLE, start, DIV/DIVU: MdStall=1 combinationally this cycle; edge E0 latches
//   |rs|,|rt| (DIVU: raw), result signs, div-by-zero flag; count<=0; ->DIV.
//  DIV: MdStall=1; each edge one restoring step (rem shift-in, trial subtract,
//   quotient bit); count++. Edge with count==WIDTH-1 (E32) writes HI=rem, LO=quot
//   after sign fix; MdDone=1 for the following cycle; ->DONE.
//  DONE: MdStall=0, EXE_MdStart ignored (same held instruction advances); next edge ->IDLE.
//  Total: DIV/DIVU stall 33 cycles (start cycle + 32), pipeline advances at E33.
//  Sign fix (DIV): quot negated iff sign(rs)!=sign(rt); rem takes sign of rs.
//  0x80000000 / -1 (DIV): LO=0x80000000, HI=0 (no trap).
//  Divide by zero (DIV, DIVU): LO=0xFFFFFFFF, HI=rs; still full 33-cycle latency.
//  Unknown Funct with EXE_MdStart: no state change, no stall.
//  Flush: any state ->IDLE next edge, HI/LO unchanged, MdDone=0; MdStall=0 in that
//   cycle. Flush with start in IDLE: op not executed (MULT/MT* write suppressed).
//  HI/LO read in the cycle of a write return the old value (no internal bypass);
//   hazard logic must forward or stall MFHI/MFLO.
//  rst mid-divide: abort, HI/LO cleared to 0, ->IDLE.
// TESTING
//  MULT rs=0xFFFFFFFE(-2) rt=3 -> next cycle HI=0xFFFFFFFF LO=0xFFFFFFFA, MdStall never 1.
//  MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001.
//  DIV rs=-7 rt=2 held with stall -> MdStall high 33 cycles, MdDone pulse, LO=0xFFFFFFFD HI=0xFFFFFFFF.
//  DIVU rs=100 rt=0 -> LO=0xFFFFFFFF HI=100 after 33 cycles; DIV 0x80000000/-1 -> LO=0x80000000 HI=0.
//  DIV in progress, Flush at iteration 10 -> IDLE next edge, HI/LO keep prior values, no MdDone.
//  MTHI 0x1234 then MTLO 0x5678 back-to-back -> HI=0x1234 LO=0x5678; rst mid-DIV -> HI=LO=0, MdStall=0.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// EXE-stage HI/LO multiply/divide unit.
// MULT/MULTU/MTHI/MTLO commit in one cycle. DIV/DIVU run a radix-2 restoring
// divider over WIDTH iterations while holding the upstream pipeline via MdStall.
module exe_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE_MdStart,
  input  logic [5:0]       EXE_Funct,
  input  logic [WIDTH-1:0] EXE_busA,
  input  logic [WIDTH-1:0] EXE_busB,
  input  logic             Flush,
  output logic             MdStall,
  output logic             MdDone,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand decode and magnitude preparation for the divider
  logic             start_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign start_div = EXE_MdStart && ((EXE_Funct == FN_DIV) || (EXE_Funct == FN_DIVU));
  assign a_neg     = (EXE_Funct == FN_DIV) && EXE_busA[WIDTH-1];
  assign b_neg     = (EXE_Funct == FN_DIV) && EXE_busB[WIDTH-1];
  assign a_mag     = a_neg ? -EXE_busA : EXE_busA;
  assign b_mag     = b_neg ? -EXE_busB : EXE_busB;

  // Full-width signed and unsigned products
  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic        [2*WIDTH-1:0] prod_u;

  assign a_sx   = {{WIDTH{EXE_busA[WIDTH-1]}}, EXE_busA};
  assign b_sx   = {{WIDTH{EXE_busB[WIDTH-1]}}, EXE_busB};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, EXE_busA} * {{WIDTH{1'b0}}, EXE_busB};

  // One restoring-division step: shift in next dividend bit, trial subtract
  logic [WIDTH:0]   rem_sh, trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx, quot_nx;

  assign rem_sh  = {rem_q, quot_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign qbit    = ~trial[WIDTH];
  assign rem_nx  = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quot_nx = {quot_q[WIDTH-2:0], qbit};

  // Stall is combinational so the start cycle itself is already held
  assign MdStall = !rst && !Flush &&
                   (((state_q == ST_IDLE) && start_div) || (state_q == ST_DIV));

  assign MdDone = done_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    rs_d    = rs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (Flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (EXE_MdStart) begin
            unique case (EXE_Funct)
              FN_MULT:  {hi_d, lo_d} = prod_s;
              FN_MULTU: {hi_d, lo_d} = prod_u;
              FN_MTHI:  hi_d = EXE_busA;
              FN_MTLO:  lo_d = EXE_busA;
              FN_DIV, FN_DIVU: begin
                rem_d   = '0;
                quot_d  = a_mag;
                dvs_d   = b_mag;
                rs_d    = EXE_busA;
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
                dbz_d   = (EXE_busB == '0);
                count_d = '0;
                state_d = ST_DIV;
              end
              default: ;
            endcase
          end
        end
        ST_DIV: begin
          rem_d   = rem_nx;
          quot_d  = quot_nx;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            if (dbz_q) begin
              hi_d = rs_q;
              lo_d = '1;
            end else begin
              hi_d = negr_q ? -rem_nx : rem_nx;
              lo_d = negq_q ? -quot_nx : quot_nx;
            end
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and architectural register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      rs_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      rs_q    <= rs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: directed vector table, randomized
// operations against an arithmetic reference model, and multi-cycle corner cases.
module tb_exe_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] bus_a, bus_b;
  logic        flush;
  logic        md_stall, md_done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  exe_muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .EXE_MdStart (start),
    .EXE_Funct   (funct),
    .EXE_busA    (bus_a),
    .EXE_busB    (bus_b),
    .Flush       (flush),
    .MdStall     (md_stall),
    .MdDone      (md_done),
    .HI          (hi),
    .LO          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: architectural result of one op given current HI/LO
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint          ps;
    longint unsigned pu;
    int              q, r;
    case (f)
      F_MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        return 64'(ps);
      end
      F_MULTU: begin
        pu = {32'h0, a} * {32'h0, b};
        return 64'(pu);
      end
      F_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      F_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      F_MTHI:  return {a, l};
      F_MTLO:  return {h, a};
      default: return {h, l};
    endcase
  endfunction

  // Issue one op (held while stalled) and check timing and committed HI/LO
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string tag);
    int stalls;
    bit is_div;
    is_div = (f == F_DIV) || (f == F_DIVU);
    @(negedge clk);
    start = 1'b1; funct = f; bus_a = a; bus_b = b;
    #1;
    if (!is_div) begin
      check({tag, " stall"}, 32'(md_stall), 32'h0);
      @(negedge clk);
      start = 1'b0;
      #1;
    end else begin
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
        if (!md_stall) break;
        stalls++;
        @(negedge clk);
        #1;
      end
      check({tag, " stall_cycles"}, 32'(stalls), 32'd33);
      check({tag, " done_pulse"}, 32'(md_done), 32'h1);
      check({tag, " hi_at_done"}, hi, exp_hi);
      check({tag, " lo_at_done"}, lo, exp_lo);
      @(negedge clk);
      start = 1'b0;
      #1;
      check({tag, " done_clear"}, 32'(md_done), 32'h0);
    end
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp;
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [5:0]  fset [6];

    vecs[0]  = '{F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{F_MTHI,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'h0000_0001};
    vecs[3]  = '{F_MTLO,  32'h0000_5678, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678};
    vecs[4]  = '{6'h20,   32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_1234, 32'h0000_5678};
    vecs[5]  = '{F_MULT,  32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
    vecs[6]  = '{F_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[8]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[9]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[10] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[11] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[12] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[13] = '{F_DIVU,  32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000};

    fset[0] = F_MULT; fset[1] = F_MULTU; fset[2] = F_DIV;
    fset[3] = F_DIVU; fset[4] = F_MTHI;  fset[5] = F_MTLO;

    rst = 1'b1; start = 1'b0; funct = 6'h0; bus_a = '0; bus_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", 32'(md_stall), 32'h0);
    check("reset done", 32'(md_done), 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    for (int k = 0; k < 24; k++) begin
      f = fset[$urandom_range(0, 5)];
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 100));
        3:       b = -32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      exp = model(f, a, b, m_hi, m_lo);
      run_op(f, a, b, exp[63:32], exp[31:0], $sformatf("rnd%0d", k));
    end

    // Flush at iteration 10 of a divide: abort with no write and no done pulse
    @(negedge clk);
    start = 1'b1; funct = F_DIV; bus_a = 32'd1000; bus_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_div stall_in_flush", 32'(md_stall), 32'h0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_div stall_after", 32'(md_stall), 32'h0);
    check("flush_div hi", hi, m_hi);
    check("flush_div lo", lo, m_lo);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      #1;
      if (md_done !== 1'b0) begin
        check("flush_div no_done", 32'(md_done), 32'h0);
        break;
      end
    end
    check("flush_div hi_later", hi, m_hi);

    // Flush together with a single-cycle op in IDLE suppresses its write
    @(negedge clk);
    start = 1'b1; funct = F_MULT; bus_a = 32'd5; bus_b = 32'd5; flush = 1'b1;
    #1;
    check("flush_mult stall", 32'(md_stall), 32'h0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_mult hi", hi, m_hi);
    check("flush_mult lo", lo, m_lo);

    // Reset in the middle of a divide clears HI/LO and releases the stall
    @(negedge clk);
    start = 1'b1; funct = F_DIVU; bus_a = 32'd77; bus_b = 32'd7;
    repeat (5) @(negedge clk);
    #1;
    check("rst_div stall_before", 32'(md_stall), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_div stall_in_rst", 32'(md_stall), 32'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    check("rst_div hi", hi, 32'h0);
    check("rst_div lo", lo, 32'h0);
    check("rst_div stall", 32'(md_stall), 32'h0);
    check("rst_div done", 32'(md_done), 32'h0);
    m_hi = '0; m_lo = '0;

    exp = model(F_DIV, 32'hFFFF_FF9C, 32'h0000_0007, m_hi, m_lo);
    run_op(F_DIV, 32'hFFFF_FF9C, 32'h0000_0007, exp[63:32], exp[31:0], "post_rst_div");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
